// File: rtl/mor1kx_dpram_fifo_pkg.sv
// Shared constants and sizing helpers for the dual-port-RAM backed FIFO.
package mor1kx_fifo_pkg;

    localparam bit RAM_CLEAR_ON_INIT = 1'b0;

    // Storage is the RAM plus one prefetched output stage.
    function automatic int fifo_cap(input int aw);
        return (2 ** aw) + 1;
    endfunction

    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/mor1kx_dpram_fifo_if.sv
// Push/pop handshake bundle of the FIFO; master is the user, slave is the FIFO.
interface mor1kx_dpram_fifo_if
    import mor1kx_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);

    logic                                flush;
    logic                                wr_valid;
    logic [DATA_WIDTH-1:0]               wr_data;
    logic                                wr_ready;
    logic                                rd_valid;
    logic [DATA_WIDTH-1:0]               rd_data;
    logic                                rd_ready;
    logic [cnt_width(ADDR_WIDTH)-1:0]    count;
    logic                                full;
    logic                                empty;

    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count, full, empty
    );

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count, full, empty
    );

endinterface

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with registered read and optional write-to-read bypass.
module mor1kx_simple_dpram_sclk #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter bit CLEAR_ON_INIT = 1'b0,
    parameter bit ENABLE_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata;

    // NOTE: the array and read register carry no reset so the storage maps onto block RAM;
    // the controller's valid flags decide when their contents mean anything.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= din;
        if (re)
            rdata <= mem[raddr];
    end

    generate
        if (CLEAR_ON_INIT) begin : g_clear_unsupported
            $error("CLEAR_ON_INIT needs initialised storage, which this RAM does not provide");
        end

        if (ENABLE_BYPASS) begin : g_bypass
            logic [DATA_WIDTH-1:0] bypass_data;
            logic                  bypass;

            // Captured only on a read so dout holds while re is low.
            always_ff @(posedge clk) begin
                if (re) begin
                    bypass_data <= din;
                    bypass      <= we && (waddr == raddr);
                end
            end

            assign dout = bypass ? bypass_data : rdata;
        end else begin : g_no_bypass
            assign dout = rdata;
        end
    endgenerate

endmodule

// File: rtl/mor1kx_dpram_fifo.sv
// First-word-fall-through FIFO around mor1kx_simple_dpram_sclk.
// Define MOR1KX_DPRAM_FIFO_BYPASS_EN for 1-cycle push-to-pop latency via the RAM bypass.
module mor1kx_dpram_fifo
    import mor1kx_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mor1kx_dpram_fifo_if.slave     bus
);

    localparam int            CW  = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] CAP = CW'(fifo_cap(ADDR_WIDTH));
`ifdef MOR1KX_DPRAM_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         ram_cnt;
    logic [CW-1:0]         count;
    logic                  out_valid;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  re;
    logic                  ram_avail;

    assign count = ram_cnt + CW'(out_valid);
    assign full  = (count == CAP);

    assign push = bus.wr_valid & ~full & ~bus.flush;
    assign pop  = out_valid & bus.rd_ready;

    // With bypass, a push into an empty RAM is readable in the same cycle (rd_ptr == wr_ptr then).
    assign ram_avail = (ram_cnt != '0) | (BYPASS & push);
    assign re        = ram_avail & (~out_valid | bus.rd_ready) & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (re)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, re})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase

            if (re)
                out_valid <= 1'b1;
            else if (pop)
                out_valid <= 1'b0;
        end
    end

    mor1kx_simple_dpram_sclk #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .CLEAR_ON_INIT (RAM_CLEAR_ON_INIT),
        .ENABLE_BYPASS (BYPASS)
    ) u_ram (
        .clk   (clk),
        .raddr (rd_ptr),
        .re    (re),
        .waddr (wr_ptr),
        .we    (push),
        .din   (bus.wr_data),
        .dout  (bus.rd_data)
    );

    assign bus.count    = count;
    assign bus.full     = full;
    assign bus.empty    = (count == '0);
    assign bus.wr_ready = ~full;
    assign bus.rd_valid = out_valid;

endmodule
